// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants for the 800x600@72 Hz VGA raster.
//   - cnt_t        : 11-bit raster counter type (max count 1039)
//   - to_cnt()     : converts an integer timing expression to an 11-bit count
//   - DEF_*        : default 800x600@72 timing values
//   - H_/V_TOTAL, H_/V_SYNC_START/END : derived defaults for the default mode
//   - CANVAS_W/H   : visible canvas bounds, also used by the image logic
//   - RED/GRN/BLU_MSB/LSB : slice positions inside the 12-bit {R,G,B} word
package vga_pkg;

    typedef logic [10:0] cnt_t;

    function automatic cnt_t to_cnt(input int value);
        return cnt_t'(value);
    endfunction

    localparam int DEF_H_VISIBLE = 800;
    localparam int DEF_H_FRONT   = 56;
    localparam int DEF_H_SYNC    = 120;
    localparam int DEF_H_BACK    = 64;
    localparam int DEF_V_VISIBLE = 600;
    localparam int DEF_V_FRONT   = 37;
    localparam int DEF_V_SYNC    = 6;
    localparam int DEF_V_BACK    = 23;

    localparam cnt_t H_TOTAL      = to_cnt(DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK);
    localparam cnt_t V_TOTAL      = to_cnt(DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK);
    localparam cnt_t H_SYNC_START = to_cnt(DEF_H_VISIBLE + DEF_H_FRONT);
    localparam cnt_t H_SYNC_END   = to_cnt(DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC - 1);
    localparam cnt_t V_SYNC_START = to_cnt(DEF_V_VISIBLE + DEF_V_FRONT);
    localparam cnt_t V_SYNC_END   = to_cnt(DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC - 1);

    localparam cnt_t CANVAS_W = to_cnt(DEF_H_VISIBLE);
    localparam cnt_t CANVAS_H = to_cnt(DEF_V_VISIBLE);

    localparam int RED_MSB = 11;
    localparam int RED_LSB = 8;
    localparam int GRN_MSB = 7;
    localparam int GRN_LSB = 4;
    localparam int BLU_MSB = 3;
    localparam int BLU_LSB = 0;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
// Counts 0..TOTAL-1 while en is high, wrapping to 0, and decodes the sync window.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   en           : advance the count by one
//   cnt          : current position (registered)
//   sync_active  : cnt lies in [SYNC_START, SYNC_END] (active-high, polarity applied by caller)
//   wrap         : en is high while cnt is at its terminal value; the count wraps on this edge
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter cnt_t TOTAL      = H_TOTAL,
    parameter cnt_t SYNC_START = H_SYNC_START,
    parameter cnt_t SYNC_END   = H_SYNC_END
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output cnt_t cnt,
    output logic sync_active,
    output logic wrap
);

    localparam cnt_t LAST = TOTAL - cnt_t'(1);

    logic at_last;

    assign at_last     = (cnt == LAST);
    assign wrap        = en && at_last;
    assign sync_active = (cnt >= SYNC_START) && (cnt <= SYNC_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_last ? '0 : cnt + cnt_t'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 800x600@72 Hz VGA raster timing from a 100 MHz clock.
// Ports:
//   CLK100MHZ        : system clock (only clock)
//   RST              : synchronous active-high reset
//   Hindex, Vindex   : current raster position, zero-extended to 12 bits
//   canvas_valid     : current position lies inside the visible canvas
//   pixel_data       : {R,G,B} returned by the image logic for Hindex/Vindex
//   vgaRed/Green/Blue: registered colour pins (blank outside the canvas)
//   Hsync, Vsync     : registered sync pins, aligned with the colour pins
//   frame_tick       : one-clock pulse on the last pixel-enable of each frame
// Pixel rate is half the clock: a toggling tick enables every second edge.
// The output stage registers colour and sync from the same counter values, so the
// pins lag Hindex/Vindex by exactly one pixel and stay mutually aligned.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit SYNC_POL  = 1'b1
) (
    input  logic        CLK100MHZ,
    input  logic        RST,
    output logic [11:0] Hindex,
    output logic [11:0] Vindex,
    output logic        canvas_valid,
    input  logic [11:0] pixel_data,
    output logic [3:0]  vgaRed,
    output logic [3:0]  vgaGreen,
    output logic [3:0]  vgaBlue,
    output logic        Hsync,
    output logic        Vsync,
    output logic        frame_tick
);

    localparam cnt_t H_TOT = to_cnt(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam cnt_t H_SS  = to_cnt(H_VISIBLE + H_FRONT);
    localparam cnt_t H_SE  = to_cnt(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam cnt_t H_VIS = to_cnt(H_VISIBLE);
    localparam cnt_t V_TOT = to_cnt(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam cnt_t V_SS  = to_cnt(V_VISIBLE + V_FRONT);
    localparam cnt_t V_SE  = to_cnt(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam cnt_t V_VIS = to_cnt(V_VISIBLE);

    logic tick;
    cnt_t h_cnt;
    cnt_t v_cnt;
    logic h_sync_act;
    logic v_sync_act;
    logic h_wrap;
    logic v_wrap;

    // tick is 0 in the first cycle after reset, so the first count happens on the second edge.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            tick <= 1'b0;
        end else begin
            tick <= ~tick;
        end
    end

    vga_axis_counter #(
        .TOTAL      (H_TOT),
        .SYNC_START (H_SS),
        .SYNC_END   (H_SE)
    ) u_h_counter (
        .clk         (CLK100MHZ),
        .rst         (RST),
        .en          (tick),
        .cnt         (h_cnt),
        .sync_active (h_sync_act),
        .wrap        (h_wrap)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOT),
        .SYNC_START (V_SS),
        .SYNC_END   (V_SE)
    ) u_v_counter (
        .clk         (CLK100MHZ),
        .rst         (RST),
        .en          (h_wrap),
        .cnt         (v_cnt),
        .sync_active (v_sync_act),
        .wrap        (v_wrap)
    );

    assign Hindex       = {1'b0, h_cnt};
    assign Vindex       = {1'b0, v_cnt};
    assign canvas_valid = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    // v_wrap = tick && last column && last line: the edge just before (0,0).
    assign frame_tick = v_wrap;

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            vgaRed   <= '0;
            vgaGreen <= '0;
            vgaBlue  <= '0;
            Hsync    <= ~SYNC_POL;
            Vsync    <= ~SYNC_POL;
        end else if (tick) begin
            if (canvas_valid) begin
                vgaRed   <= pixel_data[RED_MSB:RED_LSB];
                vgaGreen <= pixel_data[GRN_MSB:GRN_LSB];
                vgaBlue  <= pixel_data[BLU_MSB:BLU_LSB];
            end else begin
                vgaRed   <= '0;
                vgaGreen <= '0;
                vgaBlue  <= '0;
            end
            // Active level equals SYNC_POL; idle level is its complement.
            Hsync <= ~(h_sync_act ^ SYNC_POL);
            Vsync <= ~(v_sync_act ^ SYNC_POL);
        end
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 800x600@72 Hz VGA raster timing from CLK100MHZ and drives the physical VGA pins. Supplies `Hindex`, `Vindex` and `canvas_valid` to the image logic, then samples the returned `pixel_data` and drives `vgaRed`, `vgaGreen` and `vgaBlue`. It drives `Hsync` and `Vsync` aligned to the sampled pixel. It also emits a once-per-frame `frame_tick` for game-state updates.

## Interface
Parameters:
- `H_VISIBLE`, 800, active pixels per line
- `H_FRONT`, 56, horizontal front porch (pixels)
- `H_SYNC`, 120, Hsync pulse width (pixels)
- `H_BACK`, 64, horizontal back porch (pixels)
- `V_VISIBLE`, 600, active lines
- `V_FRONT`, 37, vertical front porch (lines)
- `V_SYNC`, 6, Vsync width (lines)
- `V_BACK`, 23, vertical back porch (lines)
- `SYNC_POL`, 1, sync polarity; 1 = active-high

Ports:
- `CLK100MHZ`  in  1  system clock; the only clock
- `RST`  in  1  synchronous, active-high reset
- `Hindex`  out  12  current horizontal position (registered counter)
- `Vindex`  out  12  current vertical position (registered counter)
- `canvas_valid`  out  1  high when `Hindex<H_VISIBLE` and `Vindex<V_VISIBLE`
- `pixel_data`  in  12  {R[11:8],G[7:4],B[3:0]} from image logic; combinational function of `Hindex`/`Vindex`
- `vgaRed`, `vgaGreen`, `vgaBlue`  out  4 each  colour outputs, registered
- `Hsync`, `Vsync`  out  1  sync outputs, registered
- `frame_tick`  out  1  one-CLK100MHZ-cycle pulse per frame

## Operation
- Pixel enable: a 1-bit `tick` toggles every cycle; `pix_en = tick`. This gives 50 MHz pixel rate. All counters and output registers update only when `pix_en=1`.
- Horizontal counter `h_cnt` counts 0..H_TOTAL-1, where H_TOTAL = sum of H_* = 1040. It wraps to 0.
- Vertical counter `v_cnt` counts 0..V_TOTAL-1, where V_TOTAL = 666. It increments only on the `pix_en` where `h_cnt==H_TOTAL-1`, and wraps to 0.
- `Hindex=h_cnt`, `Vindex=v_cnt`. Both are zero-extended to 12 bits.
- Sync windows:
  - Hsync active for `h_cnt` in [H_VISIBLE+H_FRONT, +H_SYNC-1], i.e. [856,975].
  - Vsync active for `v_cnt` in [637,642].
  - The active level equals `SYNC_POL`.
- Output stage (one pixel-pipeline register), on each `pix_en`:
  - Colour registers take `pixel_data` when `canvas_valid=1`, else 0.
  - `Hsync`/`Vsync` take the sync decode of the same `h_cnt`/`v_cnt`, so colour and sync stay aligned.
- `frame_tick` is 1 exactly in the cycle where `pix_en=1`, `h_cnt==H_TOTAL-1` and `v_cnt==V_TOTAL-1` (the cycle before wrap to (0,0)). It is registered-free combinational from registered state, and is low otherwise.
- Reset values:
  - `tick=0`; `h_cnt=v_cnt=0`.
  - Colour outputs 0.
  - `Hsync`/`Vsync` at the inactive level (`~SYNC_POL`).
  - `frame_tick=0`.
- A reset asserted mid-frame returns all state to the reset values on the next clock edge, with no partial-line completion. Counting resumes from (0,0) after release.
- Width rule: counters are 11 bits internally (max 1039). The compare constants are computed in the package as 11-bit values.

## Timing
- After `RST` deasserts: cycle 0 has `tick=0`; cycle 1 has `pix_en=1`, and `h_cnt` becomes 1 on that edge.
- Each counter value is held for 2 CLK100MHZ cycles.
- Latency:
  - `Hindex`/`Vindex` to colour pin: 1 pixel (2 clocks).
  - `pixel_data` is sampled at the end of the counter's 2-cycle window, so the image logic has at most 2 clocks of combinational settle.
- Line period: 2080 clocks. Frame period: 1,385,280 clocks (72.19 Hz).
- `canvas_valid` changes in the same cycle as the counters.

## Structure
- Package `vga_pkg`:
  - H_TOTAL/V_TOTAL.
  - Sync start/end constants.
  - Default 800x600@72 timing values.
  - The 12-bit RGB field slice positions.
  - Shared with the image logic for the canvas bounds 800/600.
- One natural sub-module: `vga_axis_counter`. It is a parameterised counter with enable, wrap terminal count, sync-window decode and a wrap output. It is instantiated twice (H, with enable `pix_en`; V, with enable H-wrap).

## Test plan
- Reset, then run 2080 clocks: `Hindex` goes 0..1039 and returns to 0; `Vindex` goes 0 then 1 at clock 2080; `Hsync` is high for exactly 240 clocks, starting 2 clocks after `h_cnt=856`.
- Full frame: `frame_tick` pulses exactly once per 1,385,280 clocks, one cycle wide; `Vsync` is high for 6×2080 clocks, lines 637..642 (+1 pixel delay).
- Drive `pixel_data=12'hA5C` constant: `vgaRed=A`, `vgaGreen=5`, `vgaBlue=C` for 1600 clocks per visible line; all zero during h 800..1039 and lines 600..665.
- Drive `pixel_data` as a function of `Hindex` (e.g. `Hindex[11:0]`): the colour at each output pixel equals the function of (Hindex−1), confirming the 1-pixel alignment with Hsync.
- Assert `RST` for 1 cycle at h=500, v=300: next cycle shows `Hindex=0`, `Vindex=0`, syncs inactive, colour 0, `frame_tick=0`; counting restarts correctly.
- `SYNC_POL=0`: sync outputs are inverted and idle high after reset; timing is identical.
